// File: rtl/shift_add_multiplier_param.sv
// shift_add_multiplier_param
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product,
// one partial product per clock, with a runtime signed/unsigned mode.
// Signed operands are multiplied as magnitudes, and the sign is applied
// once at the end.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        request a multiply (accepted only in IDLE with done low)
//   signed_mode  1 = two's complement operands/result, 0 = unsigned
//   A            multiplier, sampled with start
//   B            multiplicand, sampled with start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse when result is valid
//   result       product, held until the next operation completes
//
// Build option: define SHIFT_ADD_EARLY_TERM_EN to leave CALC as soon as
// the remaining multiplier bits are all zero (variable latency, same result).

module shift_add_multiplier_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PW-1:0]     result_q, result_d;

  logic [WIDTH-1:0]  a_mag;
  logic [WIDTH-1:0]  b_mag;
  logic [WIDTH-1:0]  a_shift;
  logic [PW-1:0]     addend;
  logic              last_iter;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1).
  always_comb begin
    a_mag = (signed_mode && A[WIDTH-1]) ? WIDTH'(-A) : A;
    b_mag = (signed_mode && B[WIDTH-1]) ? WIDTH'(-B) : B;
  end

  // Datapath helpers for the current iteration.
  always_comb begin
    a_shift = a_q >> 1;
    addend  = PW'(b_q) << cnt_q;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    last_iter = (a_shift == '0);
`else
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        // The done cycle is still IDLE; a start there is ignored.
        if (start && !done_q) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (a_q[0]) begin
          acc_d = acc_q + addend;
        end
        a_d   = a_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          state_d = FINISH;
        end else begin
          busy_d = 1'b1;
        end
      end
      FINISH: begin
        result_d = neg_q ? PW'(-acc_q) : acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// tb_shift_add_multiplier_param
// Directed self-checking bench for shift_add_multiplier_param at WIDTH=8.
// Honours SHIFT_ADD_EARLY_TERM_EN for the expected latencies.

module tb_shift_add_multiplier_param;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_mode;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int vectors = 0;
  int errors  = 0;

  shift_add_multiplier_param #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (signed_mode),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .result      (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Edges from the start edge to the done-visible edge.
  function automatic int exp_latency(input logic sm, input logic [7:0] a);
`ifdef SHIFT_ADD_EARLY_TERM_EN
    logic [7:0] m;
    int hb;
    m  = (sm && a[7]) ? 8'(-a) : a;
    hb = 0;
    for (int i = 0; i < 8; i++) if (m[i]) hb = i + 1;
    if (hb < 1) hb = 1;
    return hb + 1;
`else
    return 9;
`endif
  endfunction

  // Run one multiply; glitch_at >= 0 pulses a 3 x 4 start during CALC and
  // another in the done cycle, both of which must be ignored.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res,
                        input int glitch_at);
    int n;
    int nbusy;
    int lat;
    logic held_ok;
    logic [15:0] prev;
    lat     = exp_latency(sm, a);
    prev    = result;
    held_ok = 1'b1;
    n       = 0;
    nbusy   = 0;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; signed_mode = ~sm; a_in = 8'($urandom); b_in = 8'($urandom);
    while (!done && n < 40) begin
      if (busy) nbusy++;
      if (result !== prev) held_ok = 1'b0;
      start = (glitch_at >= 0) && (n == glitch_at);
      if (start) begin a_in = 8'd3; b_in = 8'd4; end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " busy_cycles"}, 32'(nbusy), 32'(lat - 1));
    check({tag, " held_mid_calc"}, 32'(held_ok), 32'd1);
    check({tag, " result"}, 32'(result), 32'(exp_res));
    if (glitch_at >= 0) begin
      start = 1'b1; a_in = 8'd3; b_in = 8'd4;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " result_hold"}, 32'(result), 32'(exp_res));
    if (glitch_at >= 0) begin
      check({tag, " start_in_done_ignored"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int n;
    logic saw_done;
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("u 127x201", 1'b0, 8'd127, 8'd201, 16'h63B7, -1);
    run_op("u 255x255", 1'b0, 8'd255, 8'd255, 16'hFE01, -1);
    run_op("u 0x0", 1'b0, 8'd0, 8'd0, 16'h0000, -1);
    run_op("u 128x2", 1'b0, 8'd128, 8'd2, 16'h0100, -1);
    run_op("s -5x7", 1'b1, 8'hFB, 8'h07, 16'hFFDD, -1);
    run_op("s -128x-128", 1'b1, 8'h80, 8'h80, 16'h4000, -1);
    run_op("s -128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, -1);
    run_op("s -1x-1", 1'b1, 8'hFF, 8'hFF, 16'h0001, -1);
    run_op("u 10x30 glitch", 1'b0, 8'd10, 8'd30, 16'd300, 0);
    run_op("u 3x4", 1'b0, 8'd3, 8'd4, 16'd12, -1);

    // Reset during the fourth CALC cycle of 50 x 50.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a_in = 8'd50; b_in = 8'd50;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    check("mid reset result", 32'(result), 32'd0);
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    for (n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("no done after abort", 32'(saw_done), 32'd0);
    check("result after abort", 32'(result), 32'd0);
    run_op("u 50x50 after reset", 1'b0, 8'd50, 8'd50, 16'd2500, -1);

    run_op("u 1x255", 1'b0, 8'd1, 8'd255, 16'd255, -1);
    run_op("u 255x1", 1'b0, 8'd255, 8'd1, 16'd255, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier_param.md
Name: shift_add_multiplier_param

Overview:
- Parametrised, handshaked successor to the team's fixed 8x8 shift-add multiplier.
- Computes a WIDTH x WIDTH product with one partial product per clock.
- Adds a runtime signed/unsigned mode, an explicit start/busy/done handshake, and result hold until the next operation.
- Used as a small-area arithmetic unit wherever a multi-cycle multiply is acceptable.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous and active-high.
- start  input  1  request a multiply; sampled only in IDLE.
- signed_mode  input  1  1 = operands and result are two's complement; 0 = unsigned. Sampled with start.
- A  input  WIDTH  multiplier; sampled with start.
- B  input  WIDTH  multiplicand; sampled with start.
- busy  output  1  high while the multiplication is in progress (CALC state).
- done  output  1  one-cycle pulse; result is valid when this is high.
- result  output  2*WIDTH  product; held stable from done until the next accepted start.

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE.
  - busy=0, done=0, result=0.
  - Internal accumulator, operand registers and counter all go to 0.
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - On a rising edge with start=1, latch the operands.
  - In signed mode, latch |A| and |B| as WIDTH-bit unsigned magnitudes and store neg = A[WIDTH-1]^B[WIDTH-1]. The most-negative value maps to 2^(WIDTH-1), which is representable unsigned.
  - In unsigned mode, latch A and B directly with neg=0.
  - Clear the accumulator and the counter, then go to CALC.
- CALC, one iteration per cycle:
  - If the multiplier LSB is 1, add the multiplicand (shifted left by the counter, 2*WIDTH-bit add with no overflow) to the accumulator.
  - Shift the multiplier right by 1 and increment the counter.
  - After WIDTH iterations go to FINISH.
- FINISH:
  - result <= neg ? two's-complement negation of the accumulator : accumulator.
  - done=1 for exactly this one cycle, then return to IDLE.
- Latency: with start sampled at edge k, busy is high for cycles k+1..k+WIDTH, and done is high in the cycle following edge k+WIDTH+1 (WIDTH=8: 9 edges after start).
- start is ignored while busy=1 or done=1. A new operation may be accepted in the first IDLE cycle after done.
- A and B may change freely after the start edge; only the latched values are used.
- result changes only in FINISH or on reset; it is never updated mid-calculation.
- Reset asserted mid-CALC aborts the operation: done is never pulsed and result reads 0.
- Special cases:
  - A zero operand gives result 0, with the same latency.
  - Signed -1 x -1 gives 1.
  - Signed min x min (WIDTH=8: -128 x -128) gives 2^(2*WIDTH-2) = 16384 with no overflow.

Optional Feature:
- Macro: SHIFT_ADD_EARLY_TERM_EN.
- Defined:
  - CALC exits to FINISH at the end of the first iteration after which the shifted multiplier register is all zeros.
  - Minimum 1 CALC cycle. Number of CALC cycles = max(1, index of highest set bit of the latched multiplier magnitude + 1).
  - The result value is identical to the fixed-latency mode.
- Not defined: CALC always lasts exactly WIDTH cycles (fixed latency).

Test Plan (WIDTH=8, early-term macro undefined unless stated):
- Unsigned 127 x 201 -> result=25527 (0x63B7); done high exactly 9 edges after the start edge; busy high 8 cycles.
- Unsigned 255 x 255 -> 65025 (0xFE01); unsigned 0 x 0 -> 0; unsigned 128 x 2 -> 256.
- Signed -5 (0xFB) x 7 -> 0xFFDD (-35); signed -128 x -128 -> 0x4000; signed -128 x 127 -> 0xC080 (-16256); signed -1 x -1 -> 0x0001.
- Pulse start with 3 x 4 during CALC of 10 x 30 -> ignored; result=300; then a new start gives 12.
- Assert rst at CALC cycle 4 of 50 x 50 -> busy, done and result go to 0 immediately; no done pulse; a following 50 x 50 gives 2500.
- With SHIFT_ADD_EARLY_TERM_EN: 1 x 255 -> 255 with 1 CALC cycle (done 2 edges after start); 255 x 1 -> 255 with 8 CALC cycles.
